// File: rtl/program_loader.sv
// Serial program loader: receives a 16-bit word count followed by little-endian
// instruction bytes and writes each assembled word into instruction memory.
module program_loader #(
  parameter int PC_SIZE = 10,
  parameter int PC_STEP = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               rw,
  output logic [PC_SIZE-1:0] PC_write,
  output logic [31:0]        instruction_in,
  output logic               reset_IF_memory,
  output logic               core_reset,
  output logic               done,
  output logic               error
);

  localparam int CAP = (2 ** PC_SIZE) / PC_STEP;
  localparam logic [PC_SIZE-1:0] STEP = PC_SIZE'(PC_STEP);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LEN0, LEN1, DATA, WRITE, DONE, ERR
  } state_t;

  state_t      state, next_state;
  logic [7:0]  len_lo;
  logic [15:0] word_total;
  logic [15:0] word_count;
  logic [1:0]  byte_count;
  logic        xfer;
  logic [15:0] len_next;

  assign xfer     = byte_valid && byte_ready;
  assign len_next = {byte_in, len_lo};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: if (start) next_state = CLEAR;
      CLEAR:           next_state = LEN0;
      LEN0:            if (xfer) next_state = LEN1;
      LEN1: begin
        if (xfer) begin
          if (len_next == 16'd0)                next_state = DONE;
          else if ({16'd0, len_next} > 32'(CAP)) next_state = ERR;
          else                                  next_state = DATA;
        end
      end
      DATA:  if (xfer && byte_count == 2'd3) next_state = WRITE;
      WRITE: begin
        if (word_count + 16'd1 == word_total) next_state = DONE;
        else                                  next_state = DATA;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    byte_ready      = (state == LEN0) || (state == LEN1) || (state == DATA);
    rw              = (state == WRITE);
    reset_IF_memory = (state == CLEAR);
    core_reset      = (state != DONE);
    done            = (state == DONE);
    error           = (state == ERR);
  end

  // Bytes shift in from the top so the first byte ends up in [7:0] after four transfers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      PC_write       <= '0;
      instruction_in <= '0;
      len_lo         <= '0;
      word_total     <= '0;
      word_count     <= '0;
      byte_count     <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            PC_write   <= '0;
            word_count <= '0;
            byte_count <= '0;
          end
        end
        LEN0: if (xfer) len_lo <= byte_in;
        LEN1: if (xfer) word_total <= len_next;
        DATA: begin
          if (xfer) begin
            instruction_in <= {byte_in, instruction_in[31:8]};
            byte_count     <= byte_count + 2'd1;
          end
        end
        WRITE: begin
          PC_write   <= PC_write + STEP;
          word_count <= word_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter PC_SIZE, default 10: width of the instruction-memory write address.
REQ-002 Parameter PC_STEP, default 4: address increment per 32-bit instruction word.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse that begins a program load.
REQ-006 byte_in  input  8  serial program byte.
REQ-007 byte_valid  input  1  byte_in carries a valid byte.
REQ-008 byte_ready  output  1  loader can accept a byte this cycle.
REQ-009 rw  output  1  instruction-memory write strobe, 1 = write.
REQ-010 PC_write  output  PC_SIZE  instruction-memory write address.
REQ-011 instruction_in  output  32  instruction word to write.
REQ-012 reset_IF_memory  output  1  clear pulse for instruction memory.
REQ-013 core_reset  output  1  holds the pipeline core in reset while loading.
REQ-014 done  output  1  load completed successfully; held until the next start.
REQ-015 error  output  1  word count exceeded capacity; held until the next start.

Function
REQ-016 The FSM SHALL use the states IDLE, CLEAR, LEN0, LEN1, DATA, WRITE, DONE and ERR.
REQ-017 A byte SHALL transfer only on a cycle with byte_valid=1 and byte_ready=1.
REQ-018 byte_ready SHALL be 1 exactly in LEN0, LEN1 and DATA.
REQ-019 IDLE/DONE/ERR + start=1 -> CLEAR; done, error and the word counter clear and PC_write becomes 0.
REQ-020 start SHALL be ignored in CLEAR, LEN0, LEN1, DATA and WRITE.
REQ-021 reset_IF_memory SHALL be 1 exactly during the single CLEAR cycle; CLEAR -> LEN0 unconditionally.
REQ-022 LEN0 captures the low byte and LEN1 the high byte of the 16-bit word count N (little-endian); each advances on transfer.
REQ-023 On the LEN1 transfer: N=0 -> DONE; N>CAP, where CAP = 2^PC_SIZE / PC_STEP (truncated), -> ERR; otherwise -> DATA.
REQ-024 DATA SHALL assemble 4 transferred bytes little-endian into instruction_in: first byte to [7:0], fourth byte to [31:24].
REQ-025 The transfer of the fourth byte SHALL move the FSM to WRITE.
REQ-026 In WRITE, rw SHALL be 1 for exactly one cycle, with PC_write and instruction_in stable.
REQ-027 After WRITE: PC_write += PC_STEP (modulo 2^PC_SIZE) and the word count increments; if it equals N -> DONE, else -> DATA.
REQ-028 rw SHALL be 0 in every state except WRITE.
REQ-029 core_reset SHALL be 1 in every state except DONE.
REQ-030 done SHALL be 1 in DONE; error SHALL be 1 in ERR.
REQ-031 A byte_valid with byte_ready=0 SHALL be neither consumed nor stored.
REQ-032 A stall on byte_valid SHALL hold all state and outputs indefinitely.
REQ-033 Latency: the rw pulse SHALL occur the cycle after the fourth byte of a word is transferred.
REQ-034 For N=CAP the last word SHALL be written at PC_write=(CAP-1)*PC_STEP; the address then wraps to 0 and DONE follows.

Reset
REQ-035 While reset=1, all outputs SHALL be forced immediately, independent of clock: state=IDLE, byte_ready=0, rw=0, PC_write=0, instruction_in=0, reset_IF_memory=0, core_reset=1, done=0, error=0.
REQ-036 reset asserted mid-load SHALL abort with no further rw pulse; a new start is required after release.

Verification
REQ-037 Normal load: start; bytes 02 00, 13 00 00 00, 93 00 10 00 -> rw pulses at PC_write=0 with 0x00000013, then at PC_write=4 with 0x00100093; then done=1 and core_reset=0.
REQ-038 Empty load: start; bytes 00 00 -> no rw pulse; reset_IF_memory pulses once; done=1.
REQ-039 Overflow: start; N=0x0101 (CAP=256) -> error=1, core_reset=1, no rw pulse; a following start clears error.
REQ-040 Backpressure: byte_valid toggled randomly during the normal load -> words, addresses and rw count identical to REQ-037.
REQ-041 Abort: reset asserted after 2 data bytes -> outputs at reset values immediately; a new full load writes from PC_write=0.
REQ-042 start pulsed during DATA -> ignored; the load completes unchanged.
